// File: rtl/vex_wb_tracker.sv
// Destination/writeback tracker: one in-order FIFO per execution class, with zero-latency
// writeback on completion and a RAW/WAW hazard check against every in-flight destination.
module vex_wb_tracker #(
  parameter int VECTOR_REGISTERS = 32,
  parameter int VECTOR_LANES     = 8,
  parameter int NUM_CLASSES      = 3,
  parameter int DEPTH            = 4,
  localparam int RW = $clog2(VECTOR_REGISTERS),
  localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int OW = $clog2(NUM_CLASSES*DEPTH+1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush_i,
  input  logic                                issue_valid_i,
  output logic                                issue_ready_o,
  input  logic [CW-1:0]                       issue_class_i,
  input  logic [RW-1:0]                       issue_dst_i,
  input  logic [VECTOR_LANES-1:0]             issue_mask_i,
  input  logic                                issue_head_i,
  input  logic                                issue_end_i,
  input  logic [RW-1:0]                       src1_i,
  input  logic [RW-1:0]                       src2_i,
  input  logic                                src1_en_i,
  input  logic                                src2_en_i,
  output logic                                hazard_o,
  input  logic [NUM_CLASSES-1:0]              cmpl_i,
  output logic [NUM_CLASSES-1:0]              wr_valid_o,
  output logic [NUM_CLASSES*RW-1:0]           wr_addr_o,
  output logic [NUM_CLASSES*VECTOR_LANES-1:0] wr_en_o,
  output logic [NUM_CLASSES-1:0]              wr_head_o,
  output logic [NUM_CLASSES-1:0]              wr_end_o,
  output logic [OW-1:0]                       occupancy_o,
  output logic                                idle_o,
  output logic                                err_underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = RW + VECTOR_LANES + 2;

  // Entry layout: {head, end, mask, dst}
  logic [EW-1:0]          mem [NUM_CLASSES][DEPTH];
  logic [PW-1:0]          rd_ptr [NUM_CLASSES];
  logic [PW-1:0]          wr_ptr [NUM_CLASSES];
  logic [PW-1:0]          cnt_nxt [NUM_CLASSES];
  logic [DEPTH-1:0]       vld_q [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] full, empty, push, pop;
  logic                   class_ok, full_sel;
  logic                   err_q;
  logic [OW-1:0]          occ_q, occ_nxt;

  always_comb begin
    class_ok = 1'b0;
    full_sel = 1'b0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      empty[c] = (rd_ptr[c] == wr_ptr[c]);
      full[c]  = (rd_ptr[c][AW-1:0] == wr_ptr[c][AW-1:0]) && (rd_ptr[c][AW] != wr_ptr[c][AW]);
      if (issue_class_i == CW'(c)) begin
        class_ok = 1'b1;
        full_sel = full[c];
      end
    end
    issue_ready_o = class_ok & ~full_sel & ~flush_i;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      push[c] = issue_valid_i & issue_ready_o & (issue_class_i == CW'(c));
      pop[c]  = cmpl_i[c] & ~empty[c];
    end
  end

  // Writeback straight from the FIFO heads; slices stay zero when their class is not popping
  always_comb begin
    wr_valid_o = pop;
    wr_addr_o  = '0;
    wr_en_o    = '0;
    wr_head_o  = '0;
    wr_end_o   = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (pop[c]) begin
        wr_addr_o[c*RW +: RW]                 = mem[c][rd_ptr[c][AW-1:0]][RW-1:0];
        wr_en_o[c*VECTOR_LANES +: VECTOR_LANES] = mem[c][rd_ptr[c][AW-1:0]][RW +: VECTOR_LANES];
        wr_end_o[c]                           = mem[c][rd_ptr[c][AW-1:0]][RW+VECTOR_LANES];
        wr_head_o[c]                          = mem[c][rd_ptr[c][AW-1:0]][RW+VECTOR_LANES+1];
      end
    end
  end

  // Conservative: an entry popping this cycle still raises the hazard
  always_comb begin
    hazard_o = 1'b0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[c][i] &&
            ((src1_en_i && mem[c][i][RW-1:0] == src1_i) ||
             (src2_en_i && mem[c][i][RW-1:0] == src2_i) ||
             (issue_valid_i && mem[c][i][RW-1:0] == issue_dst_i)))
          hazard_o = 1'b1;
      end
    end
  end

  always_comb begin
    occ_nxt = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      cnt_nxt[c] = wr_ptr[c] - rd_ptr[c] + PW'(push[c]) - PW'(pop[c]);
      occ_nxt    = occ_nxt + OW'(cnt_nxt[c]);
    end
    if (flush_i)
      occ_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        vld_q[c]  <= '0;
      end
      err_q <= 1'b0;
      occ_q <= '0;
    end else begin
      err_q <= err_q | (|(cmpl_i & empty));
      occ_q <= occ_nxt;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        if (flush_i) begin
          rd_ptr[c] <= '0;
          wr_ptr[c] <= '0;
          vld_q[c]  <= '0;
        end else begin
          if (pop[c]) begin
            rd_ptr[c]                   <= rd_ptr[c] + PW'(1);
            vld_q[c][rd_ptr[c][AW-1:0]] <= 1'b0;
          end
          if (push[c]) begin
            wr_ptr[c]                   <= wr_ptr[c] + PW'(1);
            vld_q[c][wr_ptr[c][AW-1:0]] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (push[c])
        mem[c][wr_ptr[c][AW-1:0]] <= {issue_head_i, issue_end_i, issue_mask_i, issue_dst_i};
    end
  end

  assign occupancy_o     = occ_q;
  assign idle_o          = (occ_q == '0);
  assign err_underflow_o = err_q;

endmodule

// File: tb/tb_vex_wb_tracker.sv
// Bench for vex_wb_tracker: directed scenarios followed by random traffic, all checked
// against a queue-per-class reference model.
module tb_vex_wb_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [1:0]  issue_class_i;
  logic [4:0]  issue_dst_i;
  logic [7:0]  issue_mask_i;
  logic        issue_head_i, issue_end_i;
  logic [4:0]  src1_i, src2_i;
  logic        src1_en_i, src2_en_i;
  logic        hazard_o;
  logic [2:0]  cmpl_i;
  logic [2:0]  wr_valid_o, wr_head_o, wr_end_o;
  logic [14:0] wr_addr_o;
  logic [23:0] wr_en_o;
  logic [3:0]  occupancy_o;
  logic        idle_o, err_underflow_o;

  vex_wb_tracker dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_class_i(issue_class_i), .issue_dst_i(issue_dst_i),
    .issue_mask_i(issue_mask_i), .issue_head_i(issue_head_i), .issue_end_i(issue_end_i),
    .src1_i(src1_i), .src2_i(src2_i), .src1_en_i(src1_en_i), .src2_en_i(src2_en_i),
    .hazard_o(hazard_o), .cmpl_i(cmpl_i), .wr_valid_o(wr_valid_o),
    .wr_addr_o(wr_addr_o), .wr_en_o(wr_en_o), .wr_head_o(wr_head_o), .wr_end_o(wr_end_o),
    .occupancy_o(occupancy_o), .idle_o(idle_o), .err_underflow_o(err_underflow_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] dst;
    logic [7:0] mask;
    logic       hd;
    logic       en;
  } ent_t;

  ent_t q [3][$];
  bit   err_m;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    flush_i = 0; issue_valid_i = 0; issue_class_i = 0; issue_dst_i = 0;
    issue_mask_i = 0; issue_head_i = 0; issue_end_i = 0;
    src1_i = 0; src2_i = 0; src1_en_i = 0; src2_en_i = 0; cmpl_i = 0;
  endtask

  task automatic iss(input int cls, input int dst, input logic [7:0] mask, input bit hd, input bit en);
    idle_in();
    issue_valid_i = 1; issue_class_i = 2'(cls); issue_dst_i = 5'(dst);
    issue_mask_i = mask; issue_head_i = hd; issue_end_i = en;
  endtask

  task automatic chk_rst();
    chk("rst_ready", issue_ready_o, 1);
    chk("rst_hazard", hazard_o, 0);
    chk("rst_wr_valid", wr_valid_o, 0);
    chk("rst_wr_addr", wr_addr_o, 0);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_wr_head", wr_head_o, 0);
    chk("rst_wr_end", wr_end_o, 0);
    chk("rst_occ", occupancy_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_err", err_underflow_o, 0);
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge
  task automatic cycle();
    bit       exp_ready, exp_hz, push_m;
    bit [2:0] pop_m;
    int       total;
    ent_t     e, n;
    #1;
    exp_ready = 0;
    if (issue_class_i < 3) begin
      if (!flush_i && q[int'(issue_class_i)].size() < 4) exp_ready = 1;
    end
    chk("issue_ready", issue_ready_o, exp_ready);
    exp_hz = 0;
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < q[c].size(); i++) begin
        e = q[c][i];
        if ((src1_en_i && e.dst == src1_i) || (src2_en_i && e.dst == src2_i) ||
            (issue_valid_i && e.dst == issue_dst_i))
          exp_hz = 1;
      end
    chk("hazard", hazard_o, exp_hz);
    for (int c = 0; c < 3; c++) begin
      pop_m[c] = cmpl_i[c] && q[c].size() > 0;
      chk($sformatf("wr_valid%0d", c), wr_valid_o[c], pop_m[c]);
      if (pop_m[c]) begin
        e = q[c][0];
        chk($sformatf("wr_addr%0d", c), wr_addr_o[c*5 +: 5], e.dst);
        chk($sformatf("wr_en%0d", c), wr_en_o[c*8 +: 8], e.mask);
        chk($sformatf("wr_head%0d", c), wr_head_o[c], e.hd);
        chk($sformatf("wr_end%0d", c), wr_end_o[c], e.en);
      end
    end
    push_m = issue_valid_i && exp_ready;
    for (int c = 0; c < 3; c++)
      if (cmpl_i[c] && q[c].size() == 0) err_m = 1;
    @(posedge clk);
    if (flush_i) begin
      for (int c = 0; c < 3; c++) q[c].delete();
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (pop_m[c]) void'(q[c].pop_front());
        if (push_m && int'(issue_class_i) == c) begin
          n.dst = issue_dst_i; n.mask = issue_mask_i; n.hd = issue_head_i; n.en = issue_end_i;
          q[c].push_back(n);
        end
      end
    end
    #1;
    total = q[0].size() + q[1].size() + q[2].size();
    chk("occupancy", occupancy_o, total);
    chk("idle", idle_o, total == 0);
    chk("err_underflow", err_underflow_o, err_m);
    @(negedge clk);
  endtask

  int exp_seq [3] = '{3, 4, 9};

  initial begin
    idle_in();
    rst_n = 0;
    err_m = 0;
    #1 chk_rst();
    @(negedge clk);
    rst_n = 1;

    // Single issue and completion
    iss(0, 5, 8'hFF, 1, 1); cycle();
    idle_in(); cmpl_i = 3'b001;
    #1 chk("t1_addr", wr_addr_o[4:0], 5); chk("t1_en", wr_en_o[7:0], 8'hFF);
    chk("t1_headend", {wr_head_o[0], wr_end_o[0]}, 2'b11);
    cycle();
    chk("t1_idle", idle_o, 1);

    // Fill class1, then wrap with simultaneous pop and push
    for (int d = 1; d <= 4; d++) begin iss(1, d, 8'(d), d == 1, d == 4); cycle(); end
    iss(1, 20, 8'h55, 0, 0);
    #1 chk("c1_full_ready", issue_ready_o, 0);
    cycle();
    idle_in();
    #1 chk("c0_ready", issue_ready_o, 1);
    cycle();
    idle_in(); cmpl_i = 3'b010;
    #1 chk("c1_pop1", wr_addr_o[9:5], 1);
    cycle();
    iss(1, 9, 8'hA0, 1, 1); cmpl_i = 3'b010;
    #1 chk("c1_pop2", wr_addr_o[9:5], 2);
    cycle();
    for (int k = 0; k < 3; k++) begin
      idle_in(); cmpl_i = 3'b010;
      #1 chk($sformatf("c1_seq%0d", k), wr_addr_o[9:5], exp_seq[k]);
      cycle();
    end

    // Hazard scenarios
    iss(0, 7, 8'h0F, 1, 0); cycle();
    idle_in(); src1_i = 7; src1_en_i = 1;
    #1 chk("hz_src1", hazard_o, 1);
    cycle();
    idle_in(); issue_valid_i = 1; issue_class_i = 3; issue_dst_i = 7;
    #1 chk("hz_dst", hazard_o, 1); chk("bad_class_ready", issue_ready_o, 0);
    cycle();
    idle_in(); cmpl_i = 3'b001; src1_i = 7; src1_en_i = 1; cycle();
    idle_in(); src1_i = 7; src1_en_i = 1;
    #1 chk("hz_clear", hazard_o, 0);
    cycle();

    // Underflow, push+cmpl to empty class, all-zero mask pop
    idle_in(); cmpl_i = 3'b100;
    #1 chk("uf_valid", wr_valid_o[2], 0);
    cycle();
    chk("uf_err", err_underflow_o, 1);
    iss(2, 12, 8'h00, 0, 0); cmpl_i = 3'b100;
    #1 chk("uf_push_valid", wr_valid_o[2], 0);
    cycle();
    idle_in(); cmpl_i = 3'b100;
    #1 chk("zmask_valid", wr_valid_o[2], 1); chk("zmask_en", wr_en_o[23:16], 0);
    cycle();

    // Two classes completing together
    iss(0, 3, 8'h11, 1, 0); cycle();
    iss(2, 10, 8'h22, 0, 1); cycle();
    chk("t5_occ2", occupancy_o, 2);
    idle_in(); cmpl_i = 3'b101;
    #1 chk("t5_valid", wr_valid_o, 3'b101);
    chk("t5_addr0", wr_addr_o[4:0], 3); chk("t5_addr2", wr_addr_o[14:10], 10);
    cycle();
    chk("t5_occ0", occupancy_o, 0);
    chk("t5_err_sticky", err_underflow_o, 1);

    // Flush with a concurrent issue and pop
    iss(0, 1, 8'h01, 1, 1); cycle();
    iss(1, 2, 8'h02, 1, 1); cycle();
    iss(2, 4, 8'h04, 1, 1); cycle();
    iss(1, 6, 8'h06, 1, 1); flush_i = 1; cmpl_i = 3'b001;
    #1 chk("flush_ready", issue_ready_o, 0); chk("flush_pop", wr_valid_o[0], 1);
    cycle();
    chk("flush_occ", occupancy_o, 0); chk("flush_idle", idle_o, 1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      idle_in();
      issue_valid_i = ($urandom_range(0, 1) == 1);
      issue_class_i = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue_dst_i   = 5'($urandom_range(0, 11));
      issue_mask_i  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      issue_head_i  = 1'($urandom); issue_end_i = 1'($urandom);
      src1_i = 5'($urandom_range(0, 11)); src2_i = 5'($urandom_range(0, 11));
      src1_en_i = 1'($urandom); src2_en_i = 1'($urandom);
      cmpl_i  = 3'($urandom) & 3'($urandom);
      flush_i = ($urandom_range(0, 31) == 0);
      cycle();
    end

    // Asynchronous reset mid-stream
    iss(0, 8, 8'hC3, 1, 1); flush_i = 0; cycle();
    iss(1, 9, 8'h3C, 1, 1); cycle();
    idle_in(); src1_i = 8; src1_en_i = 1;
    #1 chk("pre_rst_hazard", hazard_o, 1);
    #1 rst_n = 0;
    #1 chk_rst();
    for (int c = 0; c < 3; c++) q[c].delete();
    err_m = 0;
    @(negedge clk);
    rst_n = 1;
    idle_in(); cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
